dab_tps_modulator: RTL



---
 rtl/dab_tps_modulator.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dab_tps_modulator.sv
// Triple-phase-shift modulator: three-level V1/V2 commands, period sync, double-buffered params.
// Optional soft-start ramp of the zero-level widths is enabled with DAB_MOD_SOFTSTART_EN.
module dab_tps_modulator #(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [CNT_W-1:0]        half_in,
  input  logic [CNT_W-1:0]        d1_in,
  input  logic [CNT_W-1:0]        d2_in,
  input  logic [CNT_W-1:0]        phi_in,
  output logic signed [1:0]       V1,
  output logic signed [1:0]       V2,
  output logic                    sync,
  output logic                    running,
  output logic                    err
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0] h_a, d1_a, d2_a, phi_a;
  logic [CNT_W-1:0] h_p, d1_p, d2_p, phi_p;
  logic [CNT_W-1:0] h_s, d1_s, d2_s, phi_s;
  logic [CNT_W-1:0] d1_e, d2_e;
  logic             pend, load_now, wrap, apply, valid;
  logic [CNT_W:0]   cnt, cnt_nxt, cnt2, per;

  logic signed [1:0] v1_p1, v2_p1;
  logic              sync_p1, vld_p1, err_p1;

  // Three-level pattern over one period; a zero width >= H holds the bridge at 0.
  function automatic logic signed [1:0] level(input logic [CNT_W:0] c,
                                              input logic [CNT_W-1:0] d,
                                              input logic [CNT_W-1:0] h);
    logic [CNT_W:0] hx, dx;
    hx = {1'b0, h};
    dx = {1'b0, d};
    if (d >= h) return 2'sb00;
    if (c < hx) return (c < dx) ? 2'sb00 : 2'sb01;
    return ((c - hx) < dx) ? 2'sb00 : 2'sb11;
  endfunction

  assign per      = {h_a, 1'b0};
  assign wrap     = (state != IDLE) && (cnt == per - 1'b1);
  assign load_now = load && (state != IDLE);
  assign cnt2     = (cnt >= {1'b0, phi_a}) ? cnt - {1'b0, phi_a}
                                           : cnt + (per - {1'b0, phi_a});

  // A load landing on the wrap cycle bypasses the pending buffer.
  always_comb begin
    h_s   = load_now ? half_in : h_p;
    d1_s  = load_now ? d1_in   : d1_p;
    d2_s  = load_now ? d2_in   : d2_p;
    phi_s = load_now ? phi_in  : phi_p;
    apply = (state == IDLE) ? pend : (wrap && (pend || load));
    valid = (h_s != '0) && ({1'b0, phi_s} < {h_s, 1'b0});
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (en && (h_a != '0)) state_nxt = RUN;
      end
      RUN, STOP: begin
        cnt_nxt = wrap ? '0 : cnt + 1'b1;
        if (en)        state_nxt = RUN;
        else if (wrap) state_nxt = IDLE;
        else           state_nxt = STOP;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef DAB_MOD_SOFTSTART_EN
  logic [CNT_W-1:0] d1_t, d2_t;
  assign d1_t = (apply && valid) ? d1_s : d1_a;
  assign d2_t = (apply && valid) ? d2_s : d2_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      d1_e <= '0;
      d2_e <= '0;
    end else if (state == IDLE && state_nxt == RUN) begin
      d1_e <= h_a;
      d2_e <= h_a;
    end else if (wrap) begin
      d1_e <= (d1_e > d1_t) ? d1_e - 1'b1 : d1_t;
      d2_e <= (d2_e > d2_t) ? d2_e - 1'b1 : d2_t;
    end
  end
`else
  assign d1_e = d1_a;
  assign d2_e = d2_a;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      h_a   <= '0;  d1_a <= '0;  d2_a <= '0;  phi_a <= '0;
      h_p   <= '0;  d1_p <= '0;  d2_p <= '0;  phi_p <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (apply && valid) begin
        h_a <= h_s;  d1_a <= d1_s;  d2_a <= d2_s;  phi_a <= phi_s;
      end
      if (load && !wrap) begin
        h_p <= half_in;  d1_p <= d1_in;  d2_p <= d2_in;  phi_p <= phi_in;
        pend <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end

  // Stage p1: levels for counter c appear the cycle after cnt==c.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_p1   <= 2'sb00;
      v2_p1   <= 2'sb00;
      sync_p1 <= 1'b0;
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      v1_p1   <= (state != IDLE) ? level(cnt, d1_e, h_a)  : 2'sb00;
      v2_p1   <= (state != IDLE) ? level(cnt2, d2_e, h_a) : 2'sb00;
      sync_p1 <= (state != IDLE) && (cnt == '0);
      vld_p1  <= (state != IDLE);
      err_p1  <= apply && !valid;
    end
  end

  assign V1      = v1_p1;
  assign V2      = v2_p1;
  assign sync    = sync_p1;
  assign running = vld_p1;
  assign err     = err_p1;

endmodule
